// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch front end with branch redirect (optional IFU_PERF_CNT_EN adds counters).
// Latency: instruction valid the cycle after imem_ack; one instruction per 2 cycles at best (FETCH, FULL).
// Backpressure: holds one instruction while instr_ready is low and issues no memory request until it is taken.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

  // Branch targets are always word aligned; the low two bits carry no meaning.
  logic [ADDR_W-1:0] tgt;
  logic              unused_tgt_lo;
  assign tgt           = {redirect_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lo = ^redirect_target[1:0];

  // Next-state and datapath: a request that cannot be withdrawn is drained, a held instruction is dropped on redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d       = tgt;
          req_addr_d = tgt;
        end else begin
          req_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d       = tgt;
            req_addr_d = tgt;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(4);
            state_d    = FULL;
          end
        end else if (redirect) begin
          // Outstanding request stays on the bus; only the next fetch address moves.
          pc_d    = tgt;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_d = tgt;
        end
        if (imem_ack) begin
          req_addr_d = redirect ? tgt : pc_q;
          state_d    = FETCH;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = FETCH;
        end else if (instr_ready) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = req_addr_q;
  assign instr_valid = (state_q == FULL);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_pc    = instr_pc_q;

`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        fetch_evt;
  logic        flush_evt;

  // A flush is any redirect that throws away a held instruction or a memory request in flight.
  assign fetch_evt = (state_q == FULL) && instr_ready && !redirect;
  assign flush_evt = redirect && ((state_q == FETCH) || (state_q == FULL));

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_evt && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory latency, backpressure and redirects against a program-order model.
// The model only knows "next accepted pc = last accepted + 4, or the latest redirect target".
// Instruction contents come from an address hash with optional per-address overrides.
module tb_instr_fetch_unit;
  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_target;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .opcode(opcode),
    .instr_pc(instr_pc), .redirect(redirect), .redirect_target(redirect_target)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int n_acc = 0;
  int mem_lat = 0;
  logic [31:0] ovr [logic [31:0]];
  logic [31:0] exp_q[$];
  logic [31:0] ack_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    chk_cnt++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Memory: per-request latency, one-cycle ack pulse, data from the address hash.
  initial begin : memory
    bit mbusy;
    int mcnt, mlat;
    mbusy = 0; mcnt = 0; mlat = 0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        mbusy = 0;
      end else begin
        if (!mbusy) begin
          mbusy = 1;
          mcnt = 0;
          mlat = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (mcnt >= mlat) begin
          imem_ack = 1'b1;
          imem_rdata = mem_data(imem_addr);
          ack_q.push_back(imem_addr);
          mbusy = 0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = $urandom;
          mcnt++;
        end
      end
    end
  end

  // Monitor/scoreboard: checks every accepted instruction against program order, plus handshake rules.
  logic        p_ok = 1'b0;
  logic        p_req, p_ack, p_vld, p_rdy, p_redir;
  logic [31:0] p_addr, p_instr, p_pc;
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp_q.push_back(RPC);
      p_ok = 1'b0;
    end else begin
      if (p_ok && p_req && !p_ack) begin
        check("req_held", imem_req, 1'b1);
        check("addr_stable", imem_addr, p_addr);
      end
      if (p_ok && p_vld && !p_rdy && !p_redir) begin
        check("valid_held", instr_valid, 1'b1);
        check("instr_stable", instr, p_instr);
        check("pc_stable", instr_pc, p_pc);
      end
      if (instr_valid) check("no_req_when_full", imem_req, 1'b0);
      if (imem_req) check("addr_aligned", imem_addr[1:0], 2'b00);
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          fail_now("scoreboard_empty");
        end else begin
          e = exp_q.pop_front();
          check("acc_pc", instr_pc, e);
          check("acc_instr", instr, mem_data(e));
          check("acc_opcode", opcode, mem_data(e) >> 26);
          exp_q.push_back(e + 32'd4);
        end
        n_acc++;
      end
      if (redirect) begin
        exp_q.delete();
        exp_q.push_back(redirect_target & 32'hFFFF_FFFC);
      end
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_vld = instr_valid; p_rdy = instr_ready; p_redir = redirect;
      p_instr = instr; p_pc = instr_pc;
      p_ok = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int k);
    int target, cnt;
    target = n_acc + k;
    cnt = 0;
    while (n_acc < target && cnt < 200) begin tick(); cnt++; end
    if (n_acc < target) fail_now("wait_accept");
  endtask

  task automatic wait_valid();
    int cnt;
    cnt = 0;
    while (!instr_valid && cnt < 100) begin tick(); cnt++; end
    if (!instr_valid) fail_now("wait_valid");
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect = 1'b1;
    redirect_target = t;
    tick();
    redirect = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt + 1);
    $fatal(1);
  end

  initial begin : main
    int n, start;
    logic [31:0] old;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_target = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, RPC);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", opcode, 6'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("rst_fetch_count", fetch_count, 16'h0);
    check("rst_flush_count", flush_count, 16'h0);
`endif

    // Zero-wait memory, ready high: first valid after two edges, fetches at 0,4,8.
    @(posedge clk); #1;
    mem_lat = 0;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    n = 0;
    while (!instr_valid && n < 10) begin tick(); n++; end
    check("first_valid_latency", n, 2);
    wait_acc(3);
    if (ack_q.size() >= 3) begin
      check("fetch_addr0", ack_q[0], 32'h0);
      check("fetch_addr1", ack_q[1], 32'h4);
      check("fetch_addr2", ack_q[2], 32'h8);
    end else begin
      fail_now("fetch_addr_count");
    end

    // Backpressure on a known instruction.
    instr_ready = 1'b0;
    ovr[32'h200] = 32'h8C220004;
    pulse_redirect(32'h200);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check("bp_instr", instr, 32'h8C220004);
      check("bp_opcode", opcode, 6'h23);
      check("bp_pc", instr_pc, 32'h200);
      check("bp_no_req", imem_req, 1'b0);
    end
    tick();
    instr_ready = 1'b1;
    wait_acc(1);

    // Redirect while FULL with ready high: instruction dropped, refetch at aligned target.
    instr_ready = 1'b0;
    wait_valid();
    start = n_acc;
    instr_ready = 1'b1;
    pulse_redirect(32'h103);
    instr_ready = 1'b0;
    @(negedge clk);
    check("redir_full_no_accept", n_acc, start);
    check("redir_full_req", imem_req, 1'b1);
    check("redir_full_addr", imem_addr, 32'h100);
    wait_valid();
    check("redir_full_pc", instr_pc, 32'h100);
    instr_ready = 1'b1;
    wait_acc(1);

    // Redirect in FETCH with slow memory, second redirect while draining.
    instr_ready = 1'b0;
    wait_valid();
    mem_lat = 3;
    instr_ready = 1'b1;
    tick();
    old = imem_addr;
    check("drain_req_start", imem_req, 1'b1);
    redirect = 1'b1;
    redirect_target = 32'h300;
    @(negedge clk);
    check("drain_addr_a", imem_addr, old);
    tick();
    redirect_target = 32'h400;
    @(negedge clk);
    check("drain_addr_b", imem_addr, old);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("drain_addr_c", imem_addr, old);
    tick();
    @(negedge clk);
    check("drain_addr_d", imem_addr, old);
    check("drain_ack", imem_ack, 1'b1);
    tick();
    @(negedge clk);
    check("drain_new_req", imem_req, 1'b1);
    check("drain_new_addr", imem_addr, 32'h400);
    mem_lat = 0;
    wait_acc(1);

    // PC wrap from the last word of the address space.
    instr_ready = 1'b0;
    wait_valid();
    pulse_redirect(32'hFFFF_FFFC);
    wait_valid();
    check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 32'h0);
    instr_ready = 1'b1;
    wait_acc(1);

    // Random traffic.
    mem_lat = -1;
    start = n_acc;
    repeat (3000) begin
      tick();
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
    end
    tick();
    redirect = 1'b0;
    check("random_progress", (n_acc - start) >= 100, 1'b1);

    // Asynchronous reset while draining.
    instr_ready = 1'b0;
    wait_valid();
    mem_lat = 3;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_target = 32'h500;
    tick();
    redirect = 1'b0;
    instr_ready = 1'b0;
    check("pre_reset_drain_req", imem_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_imem_req", imem_req, 1'b0);
    check("arst_instr_valid", instr_valid, 1'b0);
    check("arst_imem_addr", imem_addr, RPC);
    check("arst_instr_pc", instr_pc, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("arst_fetch_count", fetch_count, 16'h0);
    check("arst_flush_count", flush_count, 16'h0);
`endif
    repeat (2) @(negedge clk);
    tick();
    mem_lat = 0;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    wait_acc(3);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
